// File: rtl/fetcher.sv
// fetcher: instruction-fetch stage.
//   Holds the fetch PC and keeps at most one icache request in flight. Each
//   returned word is queued for the decoder together with its PC and a
//   predicted-taken bit. The next PC comes from one of three sources:
//   - JAL targets, which are resolved locally;
//   - the 2-bit branch predictor, for B-type instructions;
//   - pc+4, for everything else.
//   A ROB flush clears the queue and redirects the PC.
// Ports:
//   clk, rst (async, active-low), rdy (global enable)
//   out_icache_valid/out_icache_pc    : request strobe and address
//   in_icache_valid/in_icache_inst    : response strobe and word
//   out_bp_tag/in_bp_jump             : predictor index and taken bit
//   out_dec_valid/inst/pc/pred_jump   : queue head towards the decoder
//   in_dec_ready                      : decoder pops the head
//   in_rob_flush/in_rob_target_pc     : redirect
module fetcher #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned BP_TAG_W = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                out_icache_valid,
    output logic [31:0]         out_icache_pc,
    input  logic                in_icache_valid,
    input  logic [31:0]         in_icache_inst,
    output logic [BP_TAG_W-1:0] out_bp_tag,
    input  logic                in_bp_jump,
    output logic                out_dec_valid,
    output logic [31:0]         out_dec_inst,
    output logic [31:0]         out_dec_pc,
    output logic                out_dec_pred_jump,
    input  logic                in_dec_ready,
    input  logic                in_rob_flush,
    input  logic [31:0]         in_rob_target_pc
);

    localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       iq_inst_q [IQ_DEPTH];
    logic [31:0]       iq_pc_q   [IQ_DEPTH];
    logic              iq_pred_q [IQ_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              flush, not_full, push, pop;
    logic [31:0]       next_pc;
    logic              next_pred;
    logic [31:0]       imm_j, imm_b;

    // Flush beats everything; a same-cycle response or pop is discarded.
    assign flush    = rdy && in_rob_flush;
    assign not_full = count_q < CNT_W'(IQ_DEPTH);
    assign push     = rdy && !in_rob_flush && (state_q == StWait) && in_icache_valid;
    assign pop      = rdy && !in_rob_flush && (count_q != '0) && in_dec_ready;

    // Next-PC selection for the returning word.
    always_comb begin
        imm_j     = {{12{in_icache_inst[31]}}, in_icache_inst[19:12], in_icache_inst[20],
                     in_icache_inst[30:21], 1'b0};
        imm_b     = {{20{in_icache_inst[31]}}, in_icache_inst[7], in_icache_inst[30:25],
                     in_icache_inst[11:8], 1'b0};
        next_pc   = pc_q + 32'd4;
        next_pred = 1'b0;
        if (in_icache_inst[6:0] == 7'b1101111) begin
            next_pc   = pc_q + imm_j;
            next_pred = 1'b1;
        end else if (in_icache_inst[6:0] == 7'b1100011 && in_bp_jump) begin
            next_pc   = pc_q + imm_b;
            next_pred = 1'b1;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = in_rob_target_pc;
        end else if (push) begin
            pc_d = next_pc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!flush && not_full) state_d = StWait;
            end
            StWait: begin
                // A response coinciding with a flush is simply dropped.
                if (in_icache_valid) state_d = StIdle;
                else if (flush)      state_d = StDiscard;
            end
            StDiscard: begin
                if (in_icache_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        // Gated by rst so the strobe stays low while reset is held.
        out_icache_valid  = rst && rdy && !in_rob_flush && (state_q == StIdle) && not_full;
        out_icache_pc     = pc_q;
        out_bp_tag        = pc_q[BP_TAG_W+1:2];
        out_dec_valid     = (count_q != '0);
        out_dec_inst      = iq_inst_q[head_q];
        out_dec_pc        = iq_pc_q[head_q];
        out_dec_pred_jump = iq_pred_q[head_q];
    end

    // Instruction queue. Pointers wrap naturally since IQ_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                iq_inst_q[i] <= '0;
                iq_pc_q[i]   <= '0;
                iq_pred_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    iq_inst_q[tail_q] <= in_icache_inst;
                    iq_pc_q[tail_q]   <= pc_q;
                    iq_pred_q[tail_q] <= next_pred;
                    tail_q            <= tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_q <= head_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!push && pop) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed testbench for fetcher. Every task starts and ends 1 time unit after
// a falling clock edge, so inputs change and outputs are sampled mid-cycle.
module tb_fetcher;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JAL  = 32'h0200006F;  // jal x0, +0x20
    localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0, x0, -8

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        out_icache_valid;
    logic [31:0] out_icache_pc;
    logic        in_icache_valid;
    logic [31:0] in_icache_inst;
    logic [7:0]  out_bp_tag;
    logic        in_bp_jump;
    logic        out_dec_valid;
    logic [31:0] out_dec_inst, out_dec_pc;
    logic        out_dec_pred_jump;
    logic        in_dec_ready, in_rob_flush;
    logic [31:0] in_rob_target_pc;

    int compared = 0;
    int mismatched = 0;

    fetcher #(.IQ_DEPTH(4), .BP_TAG_W(8), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .out_icache_valid  (out_icache_valid),
        .out_icache_pc     (out_icache_pc),
        .in_icache_valid   (in_icache_valid),
        .in_icache_inst    (in_icache_inst),
        .out_bp_tag        (out_bp_tag),
        .in_bp_jump        (in_bp_jump),
        .out_dec_valid     (out_dec_valid),
        .out_dec_inst      (out_dec_inst),
        .out_dec_pc        (out_dec_pc),
        .out_dec_pred_jump (out_dec_pred_jump),
        .in_dec_ready      (in_dec_ready),
        .in_rob_flush      (in_rob_flush),
        .in_rob_target_pc  (in_rob_target_pc)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a request strobe.
    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_icache_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // One-cycle icache response, delivered in the cycle after the request.
    task automatic respond(input logic [31:0] inst, input logic bp);
        @(negedge clk);
        in_icache_valid = 1'b1;
        in_icache_inst  = inst;
        in_bp_jump      = bp;
        @(negedge clk);
        in_icache_valid = 1'b0;
        in_bp_jump      = 1'b0;
        #1;
    endtask

    // Redirect while IDLE; the flush also suppresses the pending request.
    task automatic redirect(input logic [31:0] target);
        in_rob_flush     = 1'b1;
        in_rob_target_pc = target;
        @(negedge clk);
        in_rob_flush = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rdy = 1'b1; in_icache_valid = 1'b0; in_icache_inst = '0;
        in_bp_jump = 1'b0; in_dec_ready = 1'b0; in_rob_flush = 1'b0; in_rob_target_pc = '0;
        #12;
        compared++;
        if (out_icache_valid !== 1'b0 || out_dec_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valids: got icache=%b dec=%b want 0 0",
                     out_icache_valid, out_dec_valid);
        end
        compared++;
        if (out_icache_pc !== 32'h0 || out_dec_inst !== 32'h0 || out_dec_pc !== 32'h0 ||
            out_dec_pred_jump !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: got pc=%h inst=%h dpc=%h pred=%b want all 0",
                     out_icache_pc, out_dec_inst, out_dec_pc, out_dec_pred_jump);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_sequential;
        bit seen;
        in_dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(seen);
            compared++;
            if (!seen || out_icache_pc !== 32'(i * 4)) begin
                mismatched++;
                $display("FAIL seq_req%0d: got seen=%b pc=%h want 1 %h",
                         i, seen, out_icache_pc, 32'(i * 4));
            end
            respond(ADDI, 1'b0);
            compared++;
            if (out_dec_valid !== 1'b1 || out_dec_pc !== 32'(i * 4) ||
                out_dec_inst !== ADDI || out_dec_pred_jump !== 1'b0) begin
                mismatched++;
                $display("FAIL seq_dec%0d: got v=%b pc=%h inst=%h pred=%b want 1 %h %h 0",
                         i, out_dec_valid, out_dec_pc, out_dec_inst, out_dec_pred_jump,
                         32'(i * 4), ADDI);
            end
        end
    endtask

    task automatic test_jal;
        bit seen;
        redirect(32'h10);
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'h10) begin
            mismatched++;
            $display("FAIL jal_req: got seen=%b pc=%h want 1 00000010", seen, out_icache_pc);
        end
        respond(JAL, 1'b0);
        compared++;
        if (out_dec_valid !== 1'b1 || out_dec_pc !== 32'h10 || out_dec_pred_jump !== 1'b1) begin
            mismatched++;
            $display("FAIL jal_entry: got v=%b pc=%h pred=%b want 1 00000010 1",
                     out_dec_valid, out_dec_pc, out_dec_pred_jump);
        end
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'h30) begin
            mismatched++;
            $display("FAIL jal_target: got seen=%b pc=%h want 1 00000030", seen, out_icache_pc);
        end
    endtask

    task automatic test_branch;
        bit seen;
        logic [31:0] exp_pc;
        for (int t = 0; t < 2; t++) begin
            logic bp;
            bp = (t == 0);
            exp_pc = bp ? 32'h38 : 32'h44;
            redirect(32'h40);
            wait_req(seen);
            compared++;
            if (!seen || out_icache_pc !== 32'h40 || out_bp_tag !== 8'h10) begin
                mismatched++;
                $display("FAIL br_req%0d: got seen=%b pc=%h tag=%h want 1 00000040 10",
                         t, seen, out_icache_pc, out_bp_tag);
            end
            respond(BEQ, bp);
            compared++;
            if (out_dec_valid !== 1'b1 || out_dec_pc !== 32'h40 || out_dec_pred_jump !== bp) begin
                mismatched++;
                $display("FAIL br_entry%0d: got v=%b pc=%h pred=%b want 1 00000040 %b",
                         t, out_dec_valid, out_dec_pc, out_dec_pred_jump, bp);
            end
            wait_req(seen);
            compared++;
            if (!seen || out_icache_pc !== exp_pc) begin
                mismatched++;
                $display("FAIL br_next%0d: got seen=%b pc=%h want 1 %h",
                         t, seen, out_icache_pc, exp_pc);
            end
        end
    endtask

    task automatic test_queue_full;
        bit seen;
        bit any;
        in_dec_ready = 1'b0;
        redirect(32'h100);
        for (int i = 0; i < 4; i++) begin
            wait_req(seen);
            compared++;
            if (!seen || out_icache_pc !== 32'h100 + 32'(i * 4)) begin
                mismatched++;
                $display("FAIL full_req%0d: got seen=%b pc=%h want 1 %h",
                         i, seen, out_icache_pc, 32'h100 + 32'(i * 4));
            end
            respond(ADDI, 1'b0);
        end
        any = 1'b0;
        repeat (4) begin
            if (out_icache_valid) any = 1'b1;
            @(negedge clk); #1;
        end
        compared++;
        if (any !== 1'b0 || out_dec_valid !== 1'b1 || out_dec_pc !== 32'h100) begin
            mismatched++;
            $display("FAIL full_stall: got strobe=%b v=%b head=%h want 0 1 00000100",
                     any, out_dec_valid, out_dec_pc);
        end
        in_dec_ready = 1'b1;
        compared++;
        if (out_icache_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL full_no_issue: got strobe=%b want 0", out_icache_valid);
        end
        @(negedge clk);
        in_dec_ready = 1'b0;
        #1;
        compared++;
        if (out_icache_valid !== 1'b1 || out_icache_pc !== 32'h110 || out_dec_pc !== 32'h104) begin
            mismatched++;
            $display("FAIL full_pop: got strobe=%b pc=%h head=%h want 1 00000110 00000104",
                     out_icache_valid, out_icache_pc, out_dec_pc);
        end
        respond(ADDI, 1'b0);
    endtask

    task automatic test_flush_wait;
        bit seen;
        in_dec_ready = 1'b1;
        redirect(32'h180);
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'h180) begin
            mismatched++;
            $display("FAIL fw_req: got seen=%b pc=%h want 1 00000180", seen, out_icache_pc);
        end
        @(negedge clk);
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h200;
        @(negedge clk);
        in_rob_flush = 1'b0;
        #1;
        compared++;
        if (out_icache_valid !== 1'b0 || out_dec_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL fw_discard: got strobe=%b v=%b want 0 0",
                     out_icache_valid, out_dec_valid);
        end
        respond(JAL, 1'b1);
        compared++;
        if (out_dec_valid !== 1'b0 || out_icache_valid !== 1'b1 || out_icache_pc !== 32'h200) begin
            mismatched++;
            $display("FAIL fw_drop: got v=%b strobe=%b pc=%h want 0 1 00000200",
                     out_dec_valid, out_icache_valid, out_icache_pc);
        end
        respond(ADDI, 1'b0);
        compared++;
        if (out_dec_valid !== 1'b1 || out_dec_pc !== 32'h200) begin
            mismatched++;
            $display("FAIL fw_refetch: got v=%b pc=%h want 1 00000200", out_dec_valid, out_dec_pc);
        end
    endtask

    task automatic test_flush_collide;
        bit seen;
        in_dec_ready = 1'b0;
        redirect(32'h0);
        for (int i = 0; i < 3; i++) begin
            wait_req(seen);
            respond(ADDI, 1'b0);
        end
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'hC || out_dec_valid !== 1'b1 || out_dec_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL fc_setup: got seen=%b pc=%h v=%b head=%h want 1 0000000c 1 00000000",
                     seen, out_icache_pc, out_dec_valid, out_dec_pc);
        end
        @(negedge clk);
        in_icache_valid = 1'b1;
        in_icache_inst = ADDI;
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h200;
        in_dec_ready = 1'b1;
        @(negedge clk);
        in_icache_valid = 1'b0;
        in_rob_flush = 1'b0;
        in_dec_ready = 1'b0;
        #1;
        compared++;
        if (out_dec_valid !== 1'b0 || out_icache_valid !== 1'b1 || out_icache_pc !== 32'h200) begin
            mismatched++;
            $display("FAIL fc_result: got v=%b strobe=%b pc=%h want 0 1 00000200",
                     out_dec_valid, out_icache_valid, out_icache_pc);
        end
    endtask

    task automatic test_rdy_hold;
        bit seen;
        bit any;
        respond(ADDI, 1'b0);
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'h204) begin
            mismatched++;
            $display("FAIL rdy_req: got seen=%b pc=%h want 1 00000204", seen, out_icache_pc);
        end
        @(negedge clk);
        rdy = 1'b0;
        in_icache_valid = 1'b1;
        in_icache_inst = JAL;
        any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (out_icache_valid || out_bp_tag !== 8'h81) any = 1'b1;
            @(negedge clk);
            in_icache_valid = 1'b0;
        end
        rdy = 1'b1;
        #1;
        compared++;
        if (any !== 1'b0) begin
            mismatched++;
            $display("FAIL rdy_hold: got strobe_or_tag_change=%b want 0", any);
        end
        compared++;
        if (out_icache_valid !== 1'b0 || out_dec_valid !== 1'b1 || out_dec_pc !== 32'h200) begin
            mismatched++;
            $display("FAIL rdy_ignored: got strobe=%b v=%b head=%h want 0 1 00000200",
                     out_icache_valid, out_dec_valid, out_dec_pc);
        end
        respond(ADDI, 1'b0);
        wait_req(seen);
        compared++;
        if (!seen || out_icache_pc !== 32'h208) begin
            mismatched++;
            $display("FAIL rdy_resume: got seen=%b pc=%h want 1 00000208", seen, out_icache_pc);
        end
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (out_icache_valid !== 1'b0 || out_dec_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rmw_reset: got strobe=%b v=%b want 0 0", out_icache_valid, out_dec_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if (out_icache_valid !== 1'b1 || out_icache_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL rmw_restart: got strobe=%b pc=%h want 1 00000000",
                     out_icache_valid, out_icache_pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_queue_full();
        test_flush_wait();
        test_flush_collide();
        test_rdy_hold();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net in case a stimulus task stalls unexpectedly.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish want finish by 50000");
        $fatal(1);
    end

endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Instruction-fetch stage. Holds the PC and issues one instruction request at a time to the icache.
- For B-type responses, reads the 2-bit branch predictor combinationally to choose the next PC; resolves JAL targets itself.
- Buffers fetched instructions, with PC and prediction bit, in a small FIFO that feeds the decoder.
- Redirects to the ROB's target PC on a misprediction flush.

Parameters:
- IQ_DEPTH, 4, instruction-queue entries (power of two, >= 2)
- BP_TAG_W, 8, predictor index width; tag = pc[BP_TAG_W+1:2]
- RESET_PC, 32'h0, PC loaded at reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when 0 all state holds
- out_icache_valid  out  1  one-cycle request strobe
- out_icache_pc  out  32  request address (the current fetch PC)
- in_icache_valid  in  1  response strobe, one cycle
- in_icache_inst  in  32  response instruction word
- out_bp_tag  out  BP_TAG_W  predictor index = out_icache_pc[BP_TAG_W+1:2]
- in_bp_jump  in  1  predictor taken bit (combinational from out_bp_tag)
- out_dec_valid  out  1  queue head valid
- out_dec_inst  out  32  head instruction
- out_dec_pc  out  32  head PC
- out_dec_pred_jump  out  1  head predicted-taken bit
- in_dec_ready  in  1  decoder accepts head this cycle
- in_rob_flush  in  1  misprediction or redirect, one cycle
- in_rob_target_pc  in  32  redirect PC

Behaviour:
- Reset (rst=0, asynchronous) gives:
  - pc=RESET_PC, state=IDLE, queue empty (head=tail=count=0)
  - out_icache_valid=0, out_dec_valid=0, out_dec_inst/pc/pred_jump=0
- States:
  - IDLE: if count<IQ_DEPTH, pulse out_icache_valid=1 with out_icache_pc=pc and go to WAIT; otherwise stay.
  - WAIT: on in_icache_valid, compute next_pc, push {inst, pc, pred}, set pc<=next_pc, go to IDLE.
  - DISCARD: a flushed request is outstanding. On in_icache_valid, drop the word and go to IDLE. pc is already redirected.
- Issue rule: at most one request outstanding. Issue is allowed at count=IQ_DEPTH-1 because the response cannot arrive in the same cycle as the request.
- Minimum request-to-request spacing is 2 cycles (IDLE→WAIT→IDLE), plus icache latency.
- Next-PC, using RV32I immediates sign-extended to 32 bits with mod-2^32 wrap:
  - opcode 1101111 (JAL): next_pc=pc+J-imm, pred=1
  - opcode 1100011 (B-type): if in_bp_jump then next_pc=pc+B-imm, pred=1; else next_pc=pc+4, pred=0
  - all others, including JALR: next_pc=pc+4, pred=0
- Predictor: in_bp_jump is sampled in the same cycle as in_icache_valid. out_bp_tag is stable throughout WAIT because pc does not change.
- Queue:
  - Circular FIFO; head and tail pointers wrap at IQ_DEPTH.
  - out_dec_* are driven combinationally from the head entry; out_dec_valid = (count != 0).
  - Pop on out_dec_valid && in_dec_ready.
  - Push and pop in the same cycle leave count unchanged, and are legal at full.
  - Pop while empty is ignored.
- Flush (in_rob_flush=1 with rdy=1), highest priority:
  - Queue cleared to count=0, pointers reset, any same-cycle push or pop discarded.
  - pc<=in_rob_target_pc. No request is issued that cycle.
  - From IDLE: go to IDLE.
  - From WAIT without a same-cycle in_icache_valid: go to DISCARD.
  - From WAIT with a same-cycle in_icache_valid: the response is dropped; go to IDLE.
  - From DISCARD: stay in DISCARD unless in_icache_valid is present the same cycle, then go to IDLE.
- rdy=0: no state change and out_icache_valid forced to 0. Responses arriving while rdy=0 are the icache's responsibility to hold; the fetcher does not sample them.
- Reset mid-WAIT: return to IDLE immediately. An icache response after reset release is illegal, because the icache shares the reset.

Test Plan:
- Reset, then icache returns addi (32'h00100093) 1 cycle after each request, in_dec_ready=1 → request PCs 0,4,8; out_dec_pc sequence 0,4,8; out_dec_pred_jump=0.
- At pc=0x10, JAL with imm=+0x20 (32'h0200006F) → next out_icache_pc=0x30; queue entry pred_jump=1.
- At pc=0x40, BEQ with imm=-8 and in_bp_jump=1 → next request 0x38, pred=1. Repeat with in_bp_jump=0 → next request 0x44, pred=0. Check out_bp_tag=0x10 at pc=0x40.
- in_dec_ready=0 with IQ_DEPTH=4 → exactly 4 pushes, then no out_icache_valid. Assert in_dec_ready=1 for one cycle → one pop, one new request issued.
- Flush to 0x200 while in WAIT → state DISCARD; the next response (any word) is not queued. Next request is 0x200; out_dec_valid=0 until it returns.
- Flush coinciding with in_icache_valid and a pop, queue holding 3 entries → count=0, response dropped, next request 0x200 issued after 1 cycle. Hold rdy=0 for 3 cycles mid-WAIT → no strobe, pc unchanged.
